voice_scheduler: RTL and testbench

//   Polyphonic voice allocator/sequencer for the shared DDS note ROM. Accepts note-on/off

---
 rtl/voice_scheduler_pkg.sv | 16 +
 rtl/voice_scheduler_select.sv | 58 +++++
 rtl/voice_scheduler.sv | 142 ++++++++++++++
 tb/tb_voice_scheduler.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/voice_scheduler_pkg.sv
// Shared definitions for the voice scheduler.
//   state_e      : sequencer states (IDLE accepts events, WAIT covers the ROM
//                  read latency, CAPT writes the fetched increment)
//   ROM_LATENCY  : registered-read latency of the note-lookup ROM in cycles
package voice_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CAPT = 2'd2
  } state_e;

  // The WAIT state spans exactly this many cycles.
  localparam int ROM_LATENCY = 1;

endpackage

// File: rtl/voice_scheduler_select.sv
// Combinational voice choice for an incoming note-on.
//   gate_i       : per-voice sounding flags
//   tags_i       : per-voice note tags, voice v at [v*ADDR_WDTH +: ADDR_WDTH]
//   note_i       : note number of the incoming note-on
//   steal_ptr_i  : voice to take when every voice is sounding
//   voice_idx_o  : chosen voice
//   steal_o      : 1 when the choice is a steal (caller advances steal_ptr)
// Priority: retrigger of a sounding voice with the same note, then the
// lowest-index silent voice, then the steal pointer.
module voice_select #(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_WDTH  = 7,
  parameter int IDX_WDTH   = 2
) (
  input  logic [NUM_VOICES-1:0]           gate_i,
  input  logic [NUM_VOICES*ADDR_WDTH-1:0] tags_i,
  input  logic [ADDR_WDTH-1:0]            note_i,
  input  logic [IDX_WDTH-1:0]             steal_ptr_i,
  output logic [IDX_WDTH-1:0]             voice_idx_o,
  output logic                            steal_o
);

  logic                match_found;
  logic [IDX_WDTH-1:0] match_idx;
  logic                free_found;
  logic [IDX_WDTH-1:0] free_idx;

  // Scan from the top down so the lowest index is the last one written.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (gate_i[v] && (tags_i[v*ADDR_WDTH +: ADDR_WDTH] == note_i)) begin
        match_found = 1'b1;
        match_idx   = IDX_WDTH'(v);
      end
      if (!gate_i[v]) begin
        free_found = 1'b1;
        free_idx   = IDX_WDTH'(v);
      end
    end
  end

  always_comb begin
    voice_idx_o = steal_ptr_i;
    steal_o     = 1'b0;
    if (match_found) begin
      voice_idx_o = match_idx;
    end else if (free_found) begin
      voice_idx_o = free_idx;
    end else begin
      steal_o = 1'b1;
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Polyphonic voice allocator / sequencer; sole master of the note-lookup ROM.
//   clk, rst_n   : clock, asynchronous active-low reset
//   evt_valid/evt_ready/evt_on/evt_note : note-on/off event handshake
//   rom_addr     : registered address to the note ROM
//   rom_data     : ROM registered read data
//   voice_gate   : per-voice sounding flag
//   voice_inc    : per-voice phase increment, voice v at [v*DATA_WDTH +: DATA_WDTH]
//   voice_upd    : one-cycle pulse on the voice whose increment was just written
// A note-on selects a voice and launches a ROM fetch; the increment and the gate
// are written together two edges later, so a gate never rises ahead of its
// increment. Note-offs complete in IDLE without touching the ROM.
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int DATA_WDTH  = 16,
  parameter int ADDR_WDTH  = 7
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            evt_valid,
  output logic                            evt_ready,
  input  logic                            evt_on,
  input  logic [ADDR_WDTH-1:0]            evt_note,
  output logic [ADDR_WDTH-1:0]            rom_addr,
  input  logic [DATA_WDTH-1:0]            rom_data,
  output logic [NUM_VOICES-1:0]           voice_gate,
  output logic [NUM_VOICES*DATA_WDTH-1:0] voice_inc,
  output logic [NUM_VOICES-1:0]           voice_upd
);

  localparam int IDX_WDTH = $clog2(NUM_VOICES);

  state_e                  state_q, state_d;
  logic [ADDR_WDTH-1:0]    rom_addr_q, rom_addr_d;
  logic [NUM_VOICES-1:0]   gate_q, gate_d;
  logic [NUM_VOICES-1:0]   upd_q, upd_d;
  logic [DATA_WDTH-1:0]    inc_q [NUM_VOICES];
  logic [DATA_WDTH-1:0]    inc_d [NUM_VOICES];
  logic [ADDR_WDTH-1:0]    tag_q [NUM_VOICES];
  logic [ADDR_WDTH-1:0]    tag_d [NUM_VOICES];
  logic [IDX_WDTH-1:0]     steal_ptr_q, steal_ptr_d;
  logic [IDX_WDTH-1:0]     pend_q, pend_d;   // voice awaiting its increment

  logic [NUM_VOICES*ADDR_WDTH-1:0] tags_flat;
  logic [IDX_WDTH-1:0]             sel_idx;
  logic                            sel_steal;
  logic                            accept;

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_flat
    assign tags_flat[gi*ADDR_WDTH +: ADDR_WDTH] = tag_q[gi];
    assign voice_inc[gi*DATA_WDTH +: DATA_WDTH] = inc_q[gi];
  end

  voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .ADDR_WDTH  (ADDR_WDTH),
    .IDX_WDTH   (IDX_WDTH)
  ) u_select (
    .gate_i      (gate_q),
    .tags_i      (tags_flat),
    .note_i      (evt_note),
    .steal_ptr_i (steal_ptr_q),
    .voice_idx_o (sel_idx),
    .steal_o     (sel_steal)
  );

  // Ready is held low for as long as reset is applied, even though the
  // state register already reads IDLE.
  assign evt_ready  = rst_n && (state_q == ST_IDLE);
  assign accept     = evt_valid && evt_ready;
  assign rom_addr   = rom_addr_q;
  assign voice_gate = gate_q;
  assign voice_upd  = upd_q;

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    gate_d      = gate_q;
    upd_d       = '0;
    inc_d       = inc_q;
    tag_d       = tag_q;
    steal_ptr_d = steal_ptr_q;
    pend_d      = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (evt_on) begin
            // Stolen voice keeps sounding its old pitch until CAPT.
            tag_d[sel_idx] = evt_note;
            rom_addr_d     = evt_note;
            pend_d         = sel_idx;
            if (sel_steal) begin
              steal_ptr_d = (steal_ptr_q == IDX_WDTH'(NUM_VOICES - 1)) ?
                            '0 : steal_ptr_q + 1'b1;
            end
            state_d = ST_WAIT;
          end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (gate_q[v] && (tag_q[v] == evt_note)) begin
                gate_d[v] = 1'b0;
              end
            end
          end
        end
      end
      ST_WAIT: state_d = ST_CAPT;   // ROM samples rom_addr on this edge
      ST_CAPT: begin
        inc_d[pend_q]  = rom_data;
        gate_d[pend_q] = 1'b1;
        upd_d[pend_q]  = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rom_addr_q  <= '0;
      gate_q      <= '0;
      upd_q       <= '0;
      steal_ptr_q <= '0;
      pend_q      <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        inc_q[v] <= '0;
        tag_q[v] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      gate_q      <= gate_d;
      upd_q       <= upd_d;
      steal_ptr_q <= steal_ptr_d;
      pend_q      <= pend_d;
      inc_q       <= inc_d;
      tag_q       <= tag_d;
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
module tb_voice_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        evt_valid;
  logic        evt_ready;
  logic        evt_on;
  logic [6:0]  evt_note;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data;
  logic [3:0]  voice_gate;
  logic [63:0] voice_inc;
  logic [3:0]  voice_upd;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what each voice is doing, in plain arrays.
  bit         m_gate [4];
  logic [6:0] m_tag  [4];
  logic [15:0] m_inc [4];
  int         m_ptr;
  logic [6:0] m_rom_addr;

  voice_scheduler #(
    .NUM_VOICES (4),
    .DATA_WDTH  (16),
    .ADDR_WDTH  (7)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_on     (evt_on),
    .evt_note   (evt_note),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .voice_gate (voice_gate),
    .voice_inc  (voice_inc),
    .voice_upd  (voice_upd)
  );

  always #5 clk = ~clk;

  // Note ROM: data = note*100, one-cycle registered read.
  always_ff @(posedge clk) rom_data <= {9'd0, rom_addr} * 16'd100;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] exp_gate();
    logic [63:0] e = '0;
    for (int i = 0; i < 4; i++) e[i] = m_gate[i];
    return e;
  endfunction

  function automatic logic [63:0] exp_inc();
    logic [63:0] e = '0;
    for (int i = 0; i < 4; i++) e[i*16 +: 16] = m_inc[i];
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_gate[i] = 1'b0;
      m_tag[i]  = '0;
      m_inc[i]  = '0;
    end
    m_ptr      = 0;
    m_rom_addr = '0;
  endtask

  // Called at a falling edge with the scheduler idle; returns at a falling edge.
  task automatic do_event(input bit on, input logic [6:0] note);
    int v = -1;
    check("ready_before", 64'(evt_ready), 64'd1);
    evt_valid = 1'b1;
    evt_on    = on;
    evt_note  = note;
    @(posedge clk);
    #1 evt_valid = 1'b0;
    if (on) begin
      for (int i = 0; i < 4; i++) if (v < 0 && m_gate[i] && m_tag[i] == note) v = i;
      for (int i = 0; i < 4; i++) if (v < 0 && !m_gate[i]) v = i;
      if (v < 0) begin
        v     = m_ptr;
        m_ptr = (m_ptr + 1) % 4;
      end
      m_tag[v]   = note;
      m_rom_addr = note;
    end else begin
      for (int i = 0; i < 4; i++) if (m_gate[i] && m_tag[i] == note) m_gate[i] = 1'b0;
    end
    @(negedge clk);
    check("gate_accept", 64'(voice_gate), exp_gate());
    check("upd_quiet", 64'(voice_upd), 64'd0);
    check("rom_addr", 64'(rom_addr), 64'(m_rom_addr));
    if (on) begin
      check("ready_wait", 64'(evt_ready), 64'd0);
      @(negedge clk);
      check("ready_capt", 64'(evt_ready), 64'd0);
      check("gate_capt", 64'(voice_gate), exp_gate());
      check("upd_capt", 64'(voice_upd), 64'd0);
      check("inc_before", voice_inc, exp_inc());
      @(negedge clk);
      m_inc[v]  = 16'({9'd0, note} * 16'd100);
      m_gate[v] = 1'b1;
      check("inc_write", voice_inc, exp_inc());
      check("gate_write", 64'(voice_gate), exp_gate());
      check("upd_pulse", 64'(voice_upd), 64'(4'b0001 << v));
      check("ready_back", 64'(evt_ready), 64'd1);
    end else begin
      check("ready_off", 64'(evt_ready), 64'd1);
      check("inc_off", voice_inc, exp_inc());
    end
    $display("evt on=%0d note=%0d voice=%0d gate=%b inc=%h", on, note, v, voice_gate, voice_inc);
  endtask

  initial begin
    rst_n     = 1'b0;
    evt_valid = 1'b0;
    evt_on    = 1'b0;
    evt_note  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(evt_ready), 64'd0);
    check("rst_gate", 64'(voice_gate), 64'd0);
    check("rst_inc", voice_inc, 64'd0);
    check("rst_upd", 64'(voice_upd), 64'd0);
    check("rst_addr", 64'(rom_addr), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill, release, refill the lowest hole, then steal twice.
    do_event(1'b1, 7'd60);
    do_event(1'b1, 7'd62);
    do_event(1'b1, 7'd64);
    do_event(1'b0, 7'd62);
    do_event(1'b1, 7'd65);
    do_event(1'b1, 7'd67);
    do_event(1'b1, 7'd69);
    do_event(1'b1, 7'd71);
    // Non-sounding note-off, then back-to-back note-offs.
    do_event(1'b0, 7'd50);
    do_event(1'b0, 7'd64);
    do_event(1'b0, 7'd64);
    do_event(1'b0, 7'd65);

    // Reset while the fetch for note-on 60 sits in CAPT.
    check("ready_pre_rst", 64'(evt_ready), 64'd1);
    evt_valid = 1'b1;
    evt_on    = 1'b1;
    evt_note  = 7'd60;
    @(posedge clk);
    #1 evt_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_gate", 64'(voice_gate), 64'd0);
    check("midrst_inc", voice_inc, 64'd0);
    check("midrst_upd", 64'(voice_upd), 64'd0);
    check("midrst_ready", 64'(evt_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_gate", 64'(voice_gate), 64'd0);
      check("post_rst_upd", 64'(voice_upd), 64'd0);
      check("post_rst_inc", voice_inc, 64'd0);
    end

    // Retrigger of a sounding note.
    do_event(1'b1, 7'd62);
    do_event(1'b1, 7'd64);
    do_event(1'b1, 7'd60);
    do_event(1'b1, 7'd60);

    // Randomised traffic over a narrow note range to force collisions.
    for (int k = 0; k < 80; k++) begin
      do_event($urandom_range(0, 9) < 6, 7'($urandom_range(60, 67)));
    end
    @(negedge clk);
    check("final_upd", 64'(voice_upd), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
